mdu_issue_ctrl: RTL and testbench
=================================

// Module: mdu_issue_ctrl
// PURPOSE
//  Issue and writeback controller for the single shared iterative multiply/divide unit (MDU) in the 5-stage core.
//  - Starts an MDU op from ID and tracks the pending destination register.
//  - Stalls ID on structural, RAW and WAW conflicts with that register.
//  - Steals a free WB register-file slot to retire the result.
//  - Its stall_ID is ORed with the load-use stall into PC_EN_IF / reg_FD_stall / reg_DE_flush.
// PARAMETERS
//  MUL_CYCLES  4   cycles from mdu_start to MUL result valid (>=1)
//  DIV_CYCLES  33  cycles from mdu_start to DIV/REM result valid (>=MUL_CYCLES)
// PORTS
//  clk          in   1  core clock, rising edge
//  rst          in   1  asynchronous, active-high reset
//  valid_ID     in   1  ID holds a real instruction
//  kill_ID      in   1  ID instruction squashed this cycle; never issues, never stalls
//  ext_stall_ID in   1  load-use stall from the hazard unit; blocks issue
//  mdu_op_ID    in   1  ID instruction is MUL/DIV/REM class
//  div_ID       in   1  1=DIV/REM latency, 0=MUL latency
//  rs1use_ID    in   1  ID reads rs1
//  rs2use_ID    in   1  ID reads rs2
//  regwrite_ID  in   1  ID writes rd
//  rs1_ID       in   5  source register 1
//  rs2_ID       in   5  source register 2
//  rd_ID        in   5  destination register
//  wb_slot_free in   1  pipeline WB stage does not write the regfile this cycle
//  mdu_start    out  1  one-cycle pulse: MDU latches ID operands and op
//  mdu_div      out  1  latency class of the started op (valid with mdu_start)
//  stall_ID     out  1  hold PC/IF-ID, bubble ID-EX
//  mdu_wb_en    out  1  write MDU result to regfile this cycle
//  mdu_wb_rd    out  5  destination for mdu_wb_en
//  mdu_busy     out  1  state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, pend_rd=0, pend_div=0. All outputs 0; combinational outputs forced 0 while rst=1.
//    Reset during RUN/WB_WAIT discards the in-flight result.
//  - States:
//    * IDLE
//    * RUN: cnt counts down
//    * WB_WAIT: result ready, waiting for a WB slot
//  - Definitions:
//    pending = (state!=IDLE) && pend_rd!=0
//    live = valid_ID && !kill_ID
//  - stall_ID = live && ( (mdu_op_ID && state!=IDLE)
//      | (pending && rs1use_ID && rs1_ID==pend_rd)
//      | (pending && rs2use_ID && rs2_ID==pend_rd)
//      | (pending && regwrite_ID && rd_ID==pend_rd) ).
//    The last term is the WAW check.
//  - mdu_start = live && mdu_op_ID && state==IDLE && !ext_stall_ID. No self-stall is possible in IDLE.
//    * On start: pend_rd<=rd_ID, pend_div<=div_ID, cnt<=(div_ID?DIV_CYCLES:MUL_CYCLES)-1, state<=RUN.
//    * cnt width = $clog2(DIV_CYCLES).
//  - RUN, cnt!=0: cnt<=cnt-1.
//  - RUN, cnt==0 (result valid), i.e. start at cycle T gives the result at T+LAT:
//    * wb_slot_free: mdu_wb_en=(pend_rd!=0) this cycle, state<=IDLE.
//    * otherwise: state<=WB_WAIT.
//  - WB_WAIT: mdu_wb_en=(pend_rd!=0) when wb_slot_free, then IDLE. The MDU holds its result until the next mdu_start.
//  - rd=0 ops: occupy the unit for full latency, never assert mdu_wb_en, never create RAW/WAW stalls.
//  - mdu_wb_rd = pend_rd at all times (0 in IDLE after reset).
//  - Retire cycle: state!=IDLE still holds, so dependent readers and new MDU ops stall one more cycle.
//    They proceed the cycle after, with no same-cycle write/read bypass.
//  - Branch flush of IF/ID does not cancel an already-started op.
// STRUCTURE
//  - mdu_defs.vh (shared): state localparams
//    * MDU_IDLE=2'd0
//    * MDU_RUN=2'd1
//    * MDU_WBW=2'd2
//    Also the hazard optype constants ALU=1, LOAD=2, STORE=3, shared with the hazard unit.
//  - Sub-module mdu_cycle_counter: loadable down-counter with a zero flag, parameterised by width.
//  - FSM, pend regs and stall logic stay in this module.
// TESTING
//  1. MUL x5 issued at T, no deps, wb_slot_free=1 -> mdu_start@T, mdu_wb_en@T+4 with rd=5, IDLE@T+5.
//  2. DIV x7 at T, next instr reads x7 -> stall_ID T+1..T+33, wb_en@T+33, reader proceeds T+34.
//  3. MUL x3, result ready but wb_slot_free=0 for 3 cycles -> state WB_WAIT, wb_en on first free cycle.
//  4. Second MUL arrives while RUN -> stall_ID=1, no mdu_start until the cycle after first retires.
//     Also: ADD x9 with no x3 dependency -> no stall.
//  5. WAW: MUL x4 pending, ADDI x4 in ID -> stall until retire. MUL x0 -> 4 cycles busy, wb_en never 1.
//  6. Assert rst at RUN cnt=10 -> all outputs 0 at once, IDLE. New MUL after release issues normally.
//     kill_ID=1 or ext_stall_ID=1 with MUL in ID -> no mdu_start.

Source files
------------

// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared definitions for the MDU issue/writeback controller.
package mdu_issue_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    // Controller state; encoding is shared with the hazard unit
    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_WBW  = 2'd2
    } mdu_state_e;

    // Hazard optype constants shared with the hazard unit
    localparam logic [1:0] OPT_ALU   = 2'd1;
    localparam logic [1:0] OPT_LOAD  = 2'd2;
    localparam logic [1:0] OPT_STORE = 2'd3;

    // Register-match helper: a used operand that names the pending destination
    function automatic logic reg_hit(
        input logic             en,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] pend
    );
        return en && (rs == pend);
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl_counter.sv
// Loadable down-counter with zero flag; saturates at zero.
module mdu_cycle_counter #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load has priority over decrement; count holds once it reaches zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// Issue and writeback controller for the shared iterative multiply/divide unit.
// Starts ops from ID, stalls ID on structural/RAW/WAW conflicts with the
// pending destination, and retires the result through a free WB slot.
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_ID,
    input  logic             kill_ID,
    input  logic             ext_stall_ID,
    input  logic             mdu_op_ID,
    input  logic             div_ID,
    input  logic             rs1use_ID,
    input  logic             rs2use_ID,
    input  logic             regwrite_ID,
    input  logic [REG_W-1:0] rs1_ID,
    input  logic [REG_W-1:0] rs2_ID,
    input  logic [REG_W-1:0] rd_ID,
    input  logic             wb_slot_free,
    output logic             mdu_start,
    output logic             mdu_div,
    output logic             stall_ID,
    output logic             mdu_wb_en,
    output logic [REG_W-1:0] mdu_wb_rd,
    output logic             mdu_busy
);

    localparam int unsigned CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    mdu_state_e       r_state;
    logic [REG_W-1:0] r_pend_rd;
    logic             r_pend_div;

    logic             w_live;
    logic             w_busy;
    logic             w_pending;
    logic             w_start;
    logic             w_cnt_zero;
    logic             w_result_rdy;
    logic             w_stall;
    logic [CNT_W-1:0] w_load_val;

    assign w_live       = valid_ID && !kill_ID;
    assign w_busy       = (r_state != MDU_IDLE);
    assign w_pending    = w_busy && (r_pend_rd != '0);
    assign w_start      = w_live && mdu_op_ID && (r_state == MDU_IDLE) && !ext_stall_ID;
    assign w_load_val   = div_ID ? DIV_LOAD : MUL_LOAD;
    // Result is valid on the last RUN cycle and throughout WB_WAIT
    assign w_result_rdy = ((r_state == MDU_RUN) && w_cnt_zero) || (r_state == MDU_WBW);

    mdu_cycle_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_start),
        .i_load_val (w_load_val),
        .i_dec      (r_state == MDU_RUN),
        .o_zero     (w_cnt_zero)
    );

    // Hazard detection: structural on the unit, RAW on either source, WAW on rd
    always_comb begin
        w_stall = 1'b0;
        if (w_live) begin
            w_stall = (mdu_op_ID && w_busy)
                    || (w_pending && reg_hit(rs1use_ID,   rs1_ID, r_pend_rd))
                    || (w_pending && reg_hit(rs2use_ID,   rs2_ID, r_pend_rd))
                    || (w_pending && reg_hit(regwrite_ID, rd_ID,  r_pend_rd));
        end
    end

    // Combinational outputs, held low while reset is asserted
    always_comb begin
        mdu_start = 1'b0;
        mdu_div   = 1'b0;
        stall_ID  = 1'b0;
        mdu_wb_en = 1'b0;
        if (!rst) begin
            mdu_start = w_start;
            mdu_div   = w_start ? div_ID : r_pend_div;
            stall_ID  = w_stall;
            mdu_wb_en = w_result_rdy && wb_slot_free && (r_pend_rd != '0);
        end
    end

    assign mdu_wb_rd = r_pend_rd;
    assign mdu_busy  = w_busy;

    // Controller FSM and pending-op registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= MDU_IDLE;
            r_pend_rd  <= '0;
            r_pend_div <= 1'b0;
        end else begin
            case (r_state)
                MDU_IDLE: begin
                    if (w_start) begin
                        r_state    <= MDU_RUN;
                        r_pend_rd  <= rd_ID;
                        r_pend_div <= div_ID;
                    end
                end
                MDU_RUN: begin
                    if (w_cnt_zero) begin
                        r_state <= wb_slot_free ? MDU_IDLE : MDU_WBW;
                    end
                end
                MDU_WBW: begin
                    if (wb_slot_free) begin
                        r_state <= MDU_IDLE;
                    end
                end
                default: r_state <= MDU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl: vector table, directed corner
// sequences and randomized traffic against a time-based reference model.
module tb_mdu_issue_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 33;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_ID, kill_ID, ext_stall_ID, mdu_op_ID, div_ID;
    logic       rs1use_ID, rs2use_ID, regwrite_ID, wb_slot_free;
    logic [4:0] rs1_ID, rs2_ID, rd_ID;
    logic       mdu_start, mdu_div, stall_ID, mdu_wb_en, mdu_busy;
    logic [4:0] mdu_wb_rd;

    always #5 clk = ~clk;

    mdu_issue_ctrl #(
        .MUL_CYCLES (MUL_LAT),
        .DIV_CYCLES (DIV_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_ID     (valid_ID),
        .kill_ID      (kill_ID),
        .ext_stall_ID (ext_stall_ID),
        .mdu_op_ID    (mdu_op_ID),
        .div_ID       (div_ID),
        .rs1use_ID    (rs1use_ID),
        .rs2use_ID    (rs2use_ID),
        .regwrite_ID  (regwrite_ID),
        .rs1_ID       (rs1_ID),
        .rs2_ID       (rs2_ID),
        .rd_ID        (rd_ID),
        .wb_slot_free (wb_slot_free),
        .mdu_start    (mdu_start),
        .mdu_div      (mdu_div),
        .stall_ID     (stall_ID),
        .mdu_wb_en    (mdu_wb_en),
        .mdu_wb_rd    (mdu_wb_rd),
        .mdu_busy     (mdu_busy)
    );

    typedef struct packed {
        logic       valid, kill, ext, op, div, r1u, r2u, rw;
        logic [4:0] rs1, rs2, rd;
        logic       free;
    } in_t;

    typedef struct packed {
        logic       start, stall, wb_en;
        logic [4:0] wb_rd;
        logic       busy;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    out_t act;
    logic act_div;
    out_t exp_o;
    logic exp_div;

    // Reference model: an op started at cycle T is ready from T+latency and
    // retires on the first ready cycle with a free WB slot.
    int         cyc     = 0;
    bit         m_busy  = 1'b0;
    logic [4:0] m_rd    = 5'd0;
    int         m_ready = 0;

    function automatic in_t mk(input int v, input int k, input int e, input int op, input int dv,
                               input int r1u, input int rs1, input int r2u, input int rs2,
                               input int rw, input int rd, input int free);
        in_t x;
        x.valid = (v != 0);   x.kill = (k != 0);   x.ext = (e != 0);
        x.op    = (op != 0);  x.div  = (dv != 0);
        x.r1u   = (r1u != 0); x.rs1  = 5'(rs1);
        x.r2u   = (r2u != 0); x.rs2  = 5'(rs2);
        x.rw    = (rw != 0);  x.rd   = 5'(rd);
        x.free  = (free != 0);
        return x;
    endfunction

    function automatic out_t mo(input int s, input int st, input int w, input int rd, input int b);
        out_t o;
        o.start = (s != 0); o.stall = (st != 0); o.wb_en = (w != 0);
        o.wb_rd = 5'(rd);   o.busy  = (b != 0);
        return o;
    endfunction

    function automatic in_t nop(input int free);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, free);
    endfunction

    function automatic in_t rnd_in();
        in_t x;
        x.valid = ($urandom_range(9, 0) < 8);
        x.kill  = ($urandom_range(9, 0) == 0);
        x.ext   = ($urandom_range(6, 0) == 0);
        x.op    = ($urandom_range(3, 0) == 0);
        x.div   = ($urandom_range(3, 0) == 0);
        x.r1u   = ($urandom_range(1, 0) == 1);
        x.r2u   = ($urandom_range(1, 0) == 1);
        x.rw    = ($urandom_range(1, 0) == 1);
        x.rs1   = 5'($urandom_range(7, 0));
        x.rs2   = 5'($urandom_range(7, 0));
        x.rd    = 5'($urandom_range(7, 0));
        x.free  = ($urandom_range(9, 0) < 7);
        return x;
    endfunction

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, a, e);
        end
    endtask

    task automatic drive(input in_t x);
        valid_ID     = x.valid; kill_ID   = x.kill;  ext_stall_ID = x.ext;
        mdu_op_ID    = x.op;    div_ID    = x.div;
        rs1use_ID    = x.r1u;   rs2use_ID = x.r2u;   regwrite_ID  = x.rw;
        rs1_ID       = x.rs1;   rs2_ID    = x.rs2;   rd_ID        = x.rd;
        wb_slot_free = x.free;
    endtask

    task automatic model_step(input in_t x);
        bit live, pending, ready;
        live    = x.valid && !x.kill;
        pending = m_busy && (m_rd != 5'd0);
        ready   = m_busy && (cyc >= m_ready);
        exp_o.start = live && x.op && !m_busy && !x.ext;
        exp_o.stall = live && ((x.op && m_busy)
                    || (pending && x.r1u && x.rs1 == m_rd)
                    || (pending && x.r2u && x.rs2 == m_rd)
                    || (pending && x.rw  && x.rd  == m_rd));
        exp_o.wb_en = ready && x.free && (m_rd != 5'd0);
        exp_o.wb_rd = m_rd;
        exp_o.busy  = m_busy;
        exp_div     = x.div;
        if (ready && x.free) m_busy = 1'b0;
        if (exp_o.start) begin
            m_busy  = 1'b1;
            m_rd    = x.rd;
            m_ready = cyc + (x.div ? DIV_LAT : MUL_LAT);
        end
    endtask

    // One clock: drive on the falling edge, sample 1 ns later, advance model
    task automatic apply(input in_t x);
        @(negedge clk);
        drive(x);
        #1;
        act     = {mdu_start, stall_ID, mdu_wb_en, mdu_wb_rd, mdu_busy};
        act_div = mdu_div;
        model_step(x);
        cyc++;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".start"}, 32'(act.start), 32'(exp_o.start));
        check({tag, ".stall"}, 32'(act.stall), 32'(exp_o.stall));
        check({tag, ".wb_en"}, 32'(act.wb_en), 32'(exp_o.wb_en));
        check({tag, ".wb_rd"}, 32'(act.wb_rd), 32'(exp_o.wb_rd));
        check({tag, ".busy"},  32'(act.busy),  32'(exp_o.busy));
        if (exp_o.start) check({tag, ".div"}, 32'(act_div), 32'(exp_div));
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, ".start"}, 32'(mdu_start), 32'd0);
        check({tag, ".div"},   32'(mdu_div),   32'd0);
        check({tag, ".stall"}, 32'(stall_ID),  32'd0);
        check({tag, ".wb_en"}, 32'(mdu_wb_en), 32'd0);
        check({tag, ".wb_rd"}, 32'(mdu_wb_rd), 32'd0);
        check({tag, ".busy"},  32'(mdu_busy),  32'd0);
    endtask

    // Assert reset on a falling edge with live ID traffic, release on the next
    task automatic reset_with(input in_t x);
        @(negedge clk);
        drive(x);
        rst = 1'b1;
        #1;
        check_zero_outs("rst");
        m_busy = 1'b0;
        m_rd   = 5'd0;
        @(negedge clk);
        drive(nop(1));
        rst = 1'b0;
    endtask

    vec_t tbl[15];

    initial begin
        // ADD-style reader of x5 and MUL issue records
        tbl[0]  = '{mk(1,0,0,1,0, 1,1, 1,2, 1,5, 1), mo(1,0,0,0,0)};
        tbl[1]  = '{mk(1,0,0,1,0, 1,3, 1,4, 1,6, 1), mo(0,1,0,5,1)};
        tbl[2]  = '{mk(1,0,0,0,0, 1,1, 1,2, 1,9, 1), mo(0,0,0,5,1)};
        tbl[3]  = '{mk(1,0,0,0,0, 1,5, 1,2, 1,9, 1), mo(0,1,0,5,1)};
        tbl[4]  = '{mk(1,0,0,0,0, 1,5, 1,2, 1,9, 1), mo(0,1,1,5,1)};
        tbl[5]  = '{mk(1,0,0,0,0, 1,5, 1,2, 1,9, 1), mo(0,0,0,5,0)};
        tbl[6]  = '{mk(1,1,0,1,0, 1,1, 1,2, 1,6, 1), mo(0,0,0,5,0)};
        tbl[7]  = '{mk(1,0,1,1,0, 1,1, 1,2, 1,6, 1), mo(0,0,0,5,0)};
        tbl[8]  = '{mk(0,0,0,1,0, 1,1, 1,2, 1,6, 1), mo(0,0,0,5,0)};
        tbl[9]  = '{mk(1,0,0,1,0, 1,1, 1,2, 1,6, 1), mo(1,0,0,5,0)};
        tbl[10] = '{nop(1), mo(0,0,0,6,1)};
        tbl[11] = '{nop(1), mo(0,0,0,6,1)};
        tbl[12] = '{nop(1), mo(0,0,0,6,1)};
        tbl[13] = '{nop(1), mo(0,0,1,6,1)};
        tbl[14] = '{nop(1), mo(0,0,0,6,0)};

        drive(nop(1));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_zero_outs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Vector table: MUL x5 latency/RAW, structural stall, kill/ext gating, MUL x6
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].i);
            check($sformatf("tbl%0d.start", i), 32'(act.start), 32'(tbl[i].o.start));
            check($sformatf("tbl%0d.stall", i), 32'(act.stall), 32'(tbl[i].o.stall));
            check($sformatf("tbl%0d.wb_en", i), 32'(act.wb_en), 32'(tbl[i].o.wb_en));
            check($sformatf("tbl%0d.wb_rd", i), 32'(act.wb_rd), 32'(tbl[i].o.wb_rd));
            check($sformatf("tbl%0d.busy",  i), 32'(act.busy),  32'(tbl[i].o.busy));
        end

        // DIV x7 followed by a reader of x7
        apply(mk(1,0,0,1,1, 1,1, 1,2, 1,7, 1));
        check("div7.start", 32'(act.start), 32'd1);
        check("div7.div",   32'(act_div),   32'd1);
        for (int k = 1; k <= 34; k++) begin
            apply(mk(1,0,0,0,0, 1,7, 0,0, 1,8, 1));
            check_model("div7");
            if (k == 1)  check("div7.stall_first", 32'(act.stall), 32'd1);
            if (k == 33) check("div7.wb_en",       32'(act.wb_en), 32'd1);
            if (k == 33) check("div7.stall_ret",   32'(act.stall), 32'd1);
            if (k == 34) check("div7.proceed",     32'(act.stall), 32'd0);
        end

        // MUL x3 with WB slot blocked for 3 cycles; unrelated ADD x9 does not stall
        apply(mk(1,0,0,1,0, 1,1, 1,2, 1,3, 1));
        check("mul3.start", 32'(act.start), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            if (k == 1)
                apply(mk(1,0,0,0,0, 1,1, 1,2, 1,9, 1));
            else
                apply(nop((k >= 4 && k <= 6) ? 0 : 1));
            check_model("mul3");
            if (k == 1)           check("mul3.add_nostall", 32'(act.stall), 32'd0);
            if (k >= 4 && k <= 6) check("mul3.wbwait",      32'(act.wb_en), 32'd0);
            if (k == 6)           check("mul3.busy_wait",   32'(act.busy),  32'd1);
            if (k == 7)           check("mul3.wb_late",     32'(act.wb_en), 32'd1);
            if (k == 8)           check("mul3.idle",        32'(act.busy),  32'd0);
        end

        // WAW: ADDI x4 while MUL x4 pending
        apply(mk(1,0,0,1,0, 1,1, 1,2, 1,4, 1));
        for (int k = 1; k <= 5; k++) begin
            apply(mk(1,0,0,0,0, 1,1, 0,0, 1,4, 1));
            check_model("waw4");
            if (k == 4) check("waw4.stall_ret", 32'(act.stall), 32'd1);
            if (k == 5) check("waw4.proceed",   32'(act.stall), 32'd0);
        end

        // MUL x0: full latency busy, no writeback, no x0 hazards
        apply(mk(1,0,0,1,0, 1,1, 1,2, 1,0, 1));
        check("mul0.start", 32'(act.start), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            apply(mk(1,0,0,0,0, 1,0, 1,0, 1,0, 1));
            check_model("mul0");
            check("mul0.no_wb", 32'(act.wb_en), 32'd0);
            if (k == 4) check("mul0.busy4", 32'(act.busy), 32'd1);
            if (k == 5) check("mul0.idle",  32'(act.busy), 32'd0);
        end

        // Reset in the middle of a DIV (counter at 10), then a fresh MUL
        apply(mk(1,0,0,1,1, 1,1, 1,2, 1,10, 1));
        for (int k = 1; k <= 22; k++) begin
            apply(nop(1));
            check_model("divrst");
        end
        reset_with(mk(1,0,0,1,0, 1,10, 1,10, 1,11, 1));
        apply(mk(1,0,0,1,0, 1,1, 1,2, 1,12, 1));
        check("postrst.start", 32'(act.start), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            apply(nop(1));
            check_model("postrst");
            if (k == 4) check("postrst.wb_en", 32'(act.wb_en), 32'd1);
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 2000; n++) begin
            apply(rnd_in());
            check_model("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
